// File: rtl/ins_fetch_unit.sv
// ins_fetch_unit: writable program memory, self-running PC, synchronous-read
// fetch, combinational decode of the registered word and a Q_DEPTH-entry
// decoded-instruction queue drained over a valid/ready handshake.
module ins_fetch_unit #(
  parameter int ADDR_W  = 8,
  parameter int Q_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [ADDR_W+3:0] prog_data,
  input  logic              redir_en,
  input  logic [ADDR_W-1:0] redir_addr,
  input  logic              dec_ready,
  output logic              dec_valid,
  output logic              dec_mode,
  output logic [3:0]        dec_long,
  output logic [2:0]        dec_short,
  output logic [ADDR_W-1:0] dec_addr,
  output logic [ADDR_W-1:0] dec_pc,
  output logic              halted
);
  localparam int INS_W = ADDR_W + 4;
  localparam int PW    = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
  localparam int CW    = $clog2(Q_DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  typedef struct packed {
    logic              mode;
    logic [3:0]        lng;
    logic [2:0]        shrt;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] pc;
  } ent_t;

  state_t            r_state, w_nstate;
  logic [INS_W-1:0]  r_mem [2**ADDR_W];
  logic [INS_W-1:0]  r_rdata;
  logic [ADDR_W-1:0] r_pc, r_pend_pc;
  logic              r_pend;
  ent_t              r_q [Q_DEPTH];
  logic [PW-1:0]     r_rd, r_wr;
  logic [CW-1:0]     r_cnt;

  logic [3:0]        w_op, w_sub;
  ent_t              w_dec, w_head;
  logic              w_stp, w_valid, w_pop, w_push, w_issue;
  logic [CW:0]       w_occ;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(Q_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Decode the registered read word; pc tag travels with it
  always_comb begin
    w_op  = r_rdata[INS_W-1:ADDR_W];
    w_sub = r_rdata[3:0];
    w_dec = '0;
    w_dec.pc = r_pend_pc;
    if (w_op == 4'h0) begin
      if (!w_sub[3]) begin
        w_dec.shrt = w_sub[2:0];
      end else begin
        w_dec.mode = 1'b1;
        w_dec.lng  = w_sub;
      end
    end else if (!w_op[3]) begin
      w_dec.shrt = w_op[2:0];
      w_dec.addr = r_rdata[ADDR_W-1:0];
    end else begin
      w_dec.mode = 1'b1;
      w_dec.lng  = w_op;
      w_dec.addr = r_rdata[ADDR_W-1:0];
    end
    w_stp = (w_op == 4'h0) && (w_sub == 4'hF);
  end

  // Handshake and issue: a redirect cancels both the pop and the push, and
  // a pending stp blocks further fetches so nothing past it is read.
  assign w_valid = (r_cnt != '0);
  assign w_pop   = w_valid & dec_ready & ~redir_en;
  assign w_push  = r_pend & ~redir_en;
  assign w_occ   = {1'b0, r_cnt} + (CW+1)'(r_pend) - (CW+1)'(w_pop);
  assign w_issue = (r_state == S_RUN) & ~redir_en &
                   (w_occ < (CW+1)'(Q_DEPTH)) & ~(r_pend & w_stp);

  // Program memory: write port plus read-first synchronous fetch port
  always_ff @(posedge clk) begin
    if (prog_we) r_mem[prog_addr] <= prog_data;
    if (w_issue) r_rdata <= r_mem[r_pc];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  // Next state: redirect always restarts fetch; stp push halts
  always_comb begin
    w_nstate = r_state;
    if (redir_en)                                 w_nstate = S_RUN;
    else if (r_state == S_RUN && w_push && w_stp) w_nstate = S_HALT;
  end

  // PC and pending-read tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= '0;
      r_pend    <= 1'b0;
      r_pend_pc <= '0;
    end else begin
      r_pend <= w_issue;
      if (redir_en)     r_pc <= redir_addr;
      else if (w_issue) r_pc <= r_pc + ADDR_W'(1);
      if (w_issue)      r_pend_pc <= r_pc;
    end
  end

  // Queue storage; contents only visible through r_cnt, so no reset needed
  always_ff @(posedge clk) begin
    if (w_push) r_q[r_wr] <= w_dec;
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (redir_en) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= nxt(r_wr);
      if (w_pop)  r_rd <= nxt(r_rd);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Head fields forced to zero when the queue is empty
  always_comb begin
    w_head = '0;
    if (w_valid) w_head = r_q[r_rd];
  end

  assign dec_valid = w_valid;
  assign dec_mode  = w_head.mode;
  assign dec_long  = w_head.lng;
  assign dec_short = w_head.shrt;
  assign dec_addr  = w_head.addr;
  assign dec_pc    = w_head.pc;
  assign halted    = (r_state == S_HALT);
endmodule

// File: doc/ins_fetch_unit.md
# ins_fetch_unit

Parametrised instruction fetch/decode unit for the accumulator CPU. It holds a writable program memory of 2^ADDR_W words of (ADDR_W+4) bits and runs its own program counter. It fetches through a synchronous-read memory, decodes each word into mode / long-opcode / short-opcode / operand-address fields, and buffers decoded instructions in a Q_DEPTH-entry queue drained by the control unit over a valid/ready handshake. It supports branch redirect, flush and stop-on-`stp` halting.

## Interface
- ADDR_W, default 8: address width; instruction width INS_W = ADDR_W+4; memory depth 2^ADDR_W.
- Q_DEPTH, default 2 (must be ≥2): decoded-instruction queue depth.

- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- prog_we  in  1  program-memory write enable.
- prog_addr  in  ADDR_W  write address.
- prog_data  in  INS_W  write data.
- redir_en  in  1  redirect: load PC, flush, enter RUN.
- redir_addr  in  ADDR_W  redirect target.
- dec_ready  in  1  consumer accepts queue head.
- dec_valid  out  1  queue head valid.
- dec_mode  out  1  1 = long-opcode format.
- dec_long  out  4  long opcode.
- dec_short  out  3  short opcode.
- dec_addr  out  ADDR_W  operand address.
- dec_pc  out  ADDR_W  address the head word was fetched from.
- halted  out  1  high in HALT.

## Operation
- Word split: op = ins[INS_W-1:ADDR_W], sub = ins[3:0], a = ins[ADDR_W-1:0].
- Decode, as {mode, short, long, addr}:
  - op[3:1]=0, op[0]=0, sub[3]=0 → {0, sub[2:0], 0, 0} (cla/com).
  - op[3:1]=0, op[0]=0, sub[3]=1 → {1, 0, sub, 0} (csl/shr/stp).
  - op[3]=0, any other op → {0, op[2:0], 0, a} (sta/lda/jmp).
  - op[3]=1 → {1, 0, op, a} (add/ban).
- stp = op 0000 with sub 1111.
- States:
  - IDLE: after reset, no fetch.
  - RUN: fetching.
  - HALT: stp fetched, no fetch.
  - Transitions: IDLE/HALT/RUN → RUN on redir_en. RUN → HALT on the edge that pushes a stp word.
- Issue: in RUN, a read at pc is issued in a cycle iff:
  - no redir_en;
  - queue count + pending − pop < Q_DEPTH;
  - the pending word is not stp.
  On issue, pc ← pc+1 modulo 2^ADDR_W and pending ← 1.
- Push: pending word is decoded combinationally from the registered read data and pushed at the next edge. Space is guaranteed by the issue rule.
- Pop: dec_valid & dec_ready removes the head.
- Empty queue: all dec_* fields drive 0.
- Redirect: on the redir_en edge, pc ← redir_addr, queue emptied, pending cleared.
  - A simultaneous pop is ignored.
  - A simultaneous stp push is discarded (no HALT).
- Program writes are allowed in any state. A same-address read and write in one cycle returns old data (read-first).
- Memory contents are not affected by reset.
- Reset (asynchronous, any time): state IDLE, pc 0, queue empty, pending 0. All outputs 0 immediately.

## Timing
- Redirect at edge E0:
  - read issued in cycle E0..E1;
  - data registered at E1;
  - pushed at E2;
  - dec_valid high after E2 (2-cycle latency).
- Steady state with dec_ready=1: one instruction per cycle.
- Backpressure: pc stops advancing once count + pending reaches Q_DEPTH. No word is lost or duplicated.
- halted rises at the stp push edge. Queued entries, including stp, remain deliverable. After halt, pc = stp address + 1.
- dec_valid stays high until popped. Head fields are stable while dec_valid & !dec_ready.

## Test plan
- ADDR_W=8, load 0x201 / 0x802 / 0x00F at 0..2, redir to 0, dec_ready=1:
  - dec_valid 2 cycles after redirect;
  - {0,010,0,01} pc0, then {1,0,1000,02} pc1, then {1,0,1111,0} pc2;
  - halted=1 at stp push; no fetch of address 3.
- Decode 0x003 / 0x004 / 0x10A / 0xC02 → {0,011,0,0}, {0,100,0,0}, {0,001,0,0A}, {1,0,1100,02}.
- Backpressure: dec_ready=0 → exactly Q_DEPTH entries queued, pc frozen. Release → consecutive dec_pc with no gap or duplicate.
- Redirect with full queue, pending read and simultaneous dec_ready=1 → next-cycle dec_valid=0; first new head has dec_pc = redir_addr.
- Wrap, ADDR_W=4: redir to 0xF with non-stp words → dec_pc sequence F, 0, 1.
- Reset mid-RUN: rst_n low between edges → dec_valid and halted 0 immediately. After release, redir to 0 replays the stored program unchanged.
